avalon_mem_responder: RTL and testbench
=======================================

# avalon_mem_responder

Avalon-MM responder memory that answers `top_level_cpu`'s bus master. It replaces the zero-wait behavioural RAM in CPU benches with a clocked, waitrequest-driven slave. Read/write latency is configurable, byte lanes are honoured, and a side-band preload port lets benches load programs before and during reset. It sits between the CPU bus pins and the testbench and gives every CPU test realistic stall behaviour.

## Interface
- `BASE_ADDR`, 32'h0000_0000, byte address that maps to word 0.
- `DEPTH`, 1024, number of 32-bit words.
- `WAIT_CYCLES`, 1, fixed wait states inserted per transaction (0..15).
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `address`  in  32  byte address from the master.
- `read`  in  1  read request; held until `waitrequest` is low.
- `write`  in  1  write request; held until `waitrequest` is low.
- `writedata`  in  32  write data.
- `byteenable`  in  4  byte-lane enables; bit i covers `writedata[8i+7:8i]`.
- `waitrequest`  out  1  high = request not yet accepted.
- `readdata`  out  32  read data, valid while `read` is high and `waitrequest` is low.
- `load_en`  in  1  preload strobe; performs a full-word write.
- `load_addr`  in  32  preload byte address.
- `load_data`  in  32  preload word.

## Operation
- Word index is `(address - BASE_ADDR) >> 2`. Bits [1:0] are ignored, so a misaligned address accesses its containing word.
- An index at or above `DEPTH` is out of range:
  - reads return 32'h0;
  - writes are dropped;
  - the handshake still completes.
- FSM states:
  - **IDLE**: on `read|write`, load the wait counter with `WAIT_CYCLES` and go to WAIT. If `WAIT_CYCLES`=0, go straight to ACK.
  - **WAIT**: decrement the counter each cycle; at 0, go to ACK.
  - **ACK**: `waitrequest`=0. `readdata` holds the registered word. A write commits the enabled lanes at the closing edge. Next state is IDLE.
- `waitrequest` = (`read|write`) && state≠ACK. It is forced to 1 while `reset` is high.
- IDLE lasts at least one cycle between transactions. A request held across the ACK edge is a new transaction.
- `read` and `write` together: the write takes effect and `readdata` returns the pre-write word.
- `byteenable`=4'b0000 on a write: handshake completes and memory is unchanged.
- The master dropping `read`/`write` before ACK: the FSM finishes its count, then ACKs with nothing committed. `waitrequest` is already low in that case.
- `load_en` writes every cycle it is asserted, independent of the FSM and of `reset`. On a same-word collision with an ACK write, the preload wins.
- Reset:
  - FSM goes to IDLE and the counter to 0;
  - `readdata` becomes 0;
  - any pending write is discarded;
  - memory contents are not cleared.

## Timing
- Request first seen at edge n. With `WAIT_CYCLES`=W, ACK is the cycle after edge n+W+1, so `waitrequest` is high for W+1 cycles.
- A transaction occupies W+2 cycles plus one IDLE cycle before the next request is sampled.
- `readdata` is registered on entry to ACK.
- A write becomes visible to a read issued in the following transaction.
- A preload at edge k is visible to any read whose ACK is entered after edge k.
- Output reset values: `waitrequest`=1 during reset, then 0 while there is no request; `readdata`=32'h0.

## Configuration
- `MEM_RANDOM_WAIT_EN` defined:
  - a 16-bit Fibonacci LFSR (taps 16,14,13,11) is seeded to 16'hACE1 on reset;
  - it advances on every IDLE→WAIT/ACK transition;
  - `lfsr[1:0]` extra wait states (0..3) are added to `WAIT_CYCLES` for that transaction;
  - the sequence is deterministic per reset.
- Undefined: latency is exactly `WAIT_CYCLES`. No LFSR logic is present.

## Structure
- Shared package `mem_bus_pkg`:
  - FSM state enum (IDLE, WAIT, ACK);
  - `WORD_W`=32 and `BE_W`=4;
  - the LFSR seed and tap constants.
- One sub-module, `mem_lfsr16`, instantiated only under `MEM_RANDOM_WAIT_EN`. The memory array and byte-lane merge stay inline.

## Test plan
- **Preload and read**: preload 0x04←32'h24020010. Read 0x04 with W=1 → `waitrequest` high for 2 cycles, then `readdata`=32'h24020010 for one cycle.
- **Byte-lane write**: write 0x08 data 32'hAABBCCDD `byteenable`=4'b0101 over a word holding 32'h11223344, then read → 32'h11BB33DD.
- **Out of range**: write `BASE_ADDR`+4·`DEPTH` with 32'hFFFFFFFF → handshake completes; a later read of the same address returns 32'h0.
- **Simultaneous read+write**: 0x10 holds 32'h1, issue read+write 32'h2 → `readdata`=32'h1; a subsequent read returns 32'h2.
- **Reset mid-WAIT**: with W=3, assert `reset` during WAIT on a write of 32'h5 → `waitrequest`=1 during reset, FSM returns to IDLE, and the word is unchanged.
- **Random waits**: with `MEM_RANDOM_WAIT_EN` defined and W=0, run 8 reads → per-read stall counts match a bench reference LFSR seeded 16'hACE1, each in 1..4.

Source files
------------

// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the Avalon-MM responder memory.
// LFSR constants are only used when MEM_RANDOM_WAIT_EN is defined.
package mem_bus_pkg;

  localparam int WORD_W = 32;
  localparam int BE_W   = 4;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Taps 16,14,13,11 expressed as bit positions 15,13,12,10
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACK
  } mem_state_e;

endpackage

// File: rtl/mem_lfsr16.sv
// 16-bit Fibonacci LFSR producing per-transaction extra wait states.
// Instantiated by avalon_mem_responder when MEM_RANDOM_WAIT_EN is defined.
module mem_lfsr16
  import mem_bus_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       step,
  output logic [1:0] extra
);

  logic [15:0] lfsr;

  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr <= LFSR_SEED;
    end else if (step) begin
      lfsr <= {lfsr[14:0], ^(lfsr & LFSR_TAPS)};
    end
  end

  assign extra = lfsr[1:0];

endmodule

// File: rtl/avalon_mem_responder.sv
// Avalon-MM responder RAM with fixed wait states, byte lanes and a preload port.
// Define MEM_RANDOM_WAIT_EN to add 0..3 LFSR-driven extra wait states per access.
module avalon_mem_responder
  import mem_bus_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          DEPTH       = 1024,
  parameter int          WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       address,
  input  logic              read,
  input  logic              write,
  input  logic [WORD_W-1:0] writedata,
  input  logic [BE_W-1:0]   byteenable,
  output logic              waitrequest,
  output logic [WORD_W-1:0] readdata,
  input  logic              load_en,
  input  logic [31:0]       load_addr,
  input  logic [WORD_W-1:0] load_data
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  mem_state_e state, state_nx;
  logic [4:0] cnt, cnt_nx;
  logic [4:0] total;
  logic [1:0] extra;

  logic [WORD_W-1:0] mem [DEPTH];

  logic [31:0]   off, load_off;
  logic          in_range, load_in_range;
  logic [AW-1:0] idx, load_idx;
  logic          req, wr_commit;

  assign req           = read | write;
  assign off           = (address - BASE_ADDR) >> 2;
  assign load_off      = (load_addr - BASE_ADDR) >> 2;
  assign in_range      = off < 32'(DEPTH);
  assign load_in_range = load_off < 32'(DEPTH);
  assign idx           = off[AW-1:0];
  assign load_idx      = load_off[AW-1:0];

`ifdef MEM_RANDOM_WAIT_EN
  logic step;

  // Advance once per accepted request, as the FSM leaves IDLE
  assign step = (state == IDLE) && req && !reset;

  mem_lfsr16 u_lfsr (
    .clk   (clk),
    .reset (reset),
    .step  (step),
    .extra (extra)
  );
`else
  assign extra = 2'b00;
`endif

  assign total = 5'(WAIT_CYCLES) + {3'b000, extra};

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    unique case (state)
      IDLE: begin
        if (req) begin
          if (total == 5'd0) begin
            state_nx = ACK;
          end else begin
            state_nx = WAIT;
            cnt_nx   = total;
          end
        end
      end
      WAIT: begin
        cnt_nx = cnt - 5'd1;
        if (cnt == 5'd1) state_nx = ACK;
      end
      ACK: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      readdata <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (state != ACK && state_nx == ACK) begin
        readdata <= in_range ? mem[idx] : '0;
      end
    end
  end

  assign waitrequest = reset | (req && state != ACK);
  assign wr_commit   = (state == ACK) && write && in_range && !reset;

  // Preload is written last so it wins a same-word collision
  always_ff @(posedge clk) begin
    if (wr_commit) begin
      for (int i = 0; i < BE_W; i++) begin
        if (byteenable[i]) mem[idx][8*i +: 8] <= writedata[8*i +: 8];
      end
    end
    if (load_en && load_in_range) begin
      mem[load_idx] <= load_data;
    end
  end

endmodule

// File: tb/tb_avalon_mem_responder.sv
// Self-checking bench for avalon_mem_responder against a word-array model.
// Build with MEM_RANDOM_WAIT_EN defined to exercise the random wait states.
module tb_avalon_mem_responder;

  localparam logic [31:0] BASE  = 32'h0000_1000;
  localparam int          DEPTH = 64;
`ifdef MEM_RANDOM_WAIT_EN
  localparam int TW = 0;
`else
  localparam int TW = 3;
`endif

  logic        clk = 0;
  logic        reset = 1;
  logic [31:0] address = '0;
  logic        read = 0;
  logic        write = 0;
  logic [31:0] writedata = '0;
  logic [3:0]  byteenable = '0;
  logic        waitrequest;
  logic [31:0] readdata;
  logic        load_en = 0;
  logic [31:0] load_addr = '0;
  logic [31:0] load_data = '0;

  int checks = 0;
  int failures = 0;

  logic [31:0] mm [DEPTH];
  logic [15:0] m_lfsr = 16'hACE1;

  bit          txn = 0;
  int          exp_s = 0;
  bit          exp_rd_en = 0;
  logic [31:0] exp_rd = '0;
  int          k = 0;

  always #5 clk = ~clk;

  avalon_mem_responder #(
    .BASE_ADDR   (BASE),
    .DEPTH       (DEPTH),
    .WAIT_CYCLES (TW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .address     (address),
    .read        (read),
    .write       (write),
    .writedata   (writedata),
    .byteenable  (byteenable),
    .waitrequest (waitrequest),
    .readdata    (readdata),
    .load_en     (load_en),
    .load_addr   (load_addr),
    .load_data   (load_data)
  );

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  function automatic bit in_rng(input logic [31:0] a);
    logic [31:0] o;
    o = a - BASE;
    return o < 32'(4 * DEPTH);
  endfunction

  function automatic int widx(input logic [31:0] a);
    logic [31:0] o;
    o = a - BASE;
    return int'(o / 4);
  endfunction

  // Per-cycle check of the handshake and the read data
  always @(negedge clk) begin
    if (reset) begin
      k = 0;
      chk("wr_reset", 32'(waitrequest), 32'd1);
    end else if (!txn) begin
      k = 0;
      chk("wr_idle", 32'(waitrequest), 32'd0);
    end else begin
      k++;
      chk("wr_txn", 32'(waitrequest), 32'(k <= exp_s + 1));
      if (k == exp_s + 2 && exp_rd_en)
        chk("readdata", readdata, exp_rd);
    end
  end

  task automatic preload(input logic [31:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    load_en = 1; load_addr = a; load_data = d;
    @(posedge clk); #1;
    load_en = 0;
    if (in_rng(a)) mm[widx(a)] = d;
  endtask

  task automatic do_txn(input bit rd, input bit wr, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] be,
                        input bit collide, input logic [31:0] cdata,
                        output int st, output logic [31:0] got);
    int  extra;
    bit  done;
    @(posedge clk); #1;
    extra = 0;
`ifdef MEM_RANDOM_WAIT_EN
    extra = int'(m_lfsr[1:0]);
    m_lfsr = lfsr_next(m_lfsr);
`endif
    exp_s = TW + extra;
    exp_rd_en = rd;
    exp_rd = in_rng(a) ? mm[widx(a)] : 32'h0;
    read = rd; write = wr; address = a; writedata = d; byteenable = be;
    txn = 1;
    st = 0; got = 'x; done = 0;
    for (int n = 0; n < 64 && !done; n++) begin
      @(negedge clk);
      if (!waitrequest) done = 1;
      else st++;
    end
    if (!done) chk("handshake_timeout", 32'd1, 32'd0);
    got = readdata;
    if (collide) begin
      load_en = 1; load_addr = a; load_data = cdata;
    end
    @(posedge clk); #1;
    read = 0; write = 0; load_en = 0; txn = 0;
    if (wr && in_rng(a)) begin
      for (int i = 0; i < 4; i++)
        if (be[i]) mm[widx(a)][8*i +: 8] = d[8*i +: 8];
    end
    if (collide && in_rng(a)) mm[widx(a)] = cdata;
    chk("stall_count", 32'(st), 32'(exp_s + 1));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int          st;
    logic [31:0] got;
    logic [31:0] a, d;
    int          op;

    // Fill memory through the preload port while reset is held
    for (int i = 0; i < DEPTH; i++) begin
      @(posedge clk); #1;
      d = $urandom;
      load_en = 1; load_addr = BASE + 32'(4 * i); load_data = d;
      mm[i] = d;
    end
    @(posedge clk); #1;
    load_en = 0;
    reset = 0;
    @(negedge clk);
    chk("readdata_after_reset", readdata, 32'h0);

    chk("lfsr_model_1", 32'(lfsr_next(16'hACE1)), 32'h0000_59C3);
    chk("lfsr_model_2", 32'(lfsr_next(lfsr_next(16'hACE1))), 32'h0000_B387);

    preload(BASE + 32'h04, 32'h2402_0010);
    do_txn(1, 0, BASE + 32'h04, 0, 4'hF, 0, 0, st, got);
    chk("preload_read", got, 32'h2402_0010);
`ifdef MEM_RANDOM_WAIT_EN
    chk("preload_stall", 32'(st), 32'd2);
`else
    chk("preload_stall", 32'(st), 32'd4);
`endif

    preload(BASE + 32'h08, 32'h1122_3344);
    do_txn(0, 1, BASE + 32'h08, 32'hAABB_CCDD, 4'b0101, 0, 0, st, got);
    do_txn(1, 0, BASE + 32'h08, 0, 4'hF, 0, 0, st, got);
    chk("byte_lane", got, 32'h11BB_33DD);
    do_txn(1, 0, BASE + 32'h0B, 0, 4'hF, 0, 0, st, got);
    chk("misaligned", got, 32'h11BB_33DD);

    do_txn(0, 1, BASE + 32'h0C, 32'hFFFF_FFFF, 4'b0000, 0, 0, st, got);
    do_txn(1, 0, BASE + 32'h0C, 0, 4'hF, 0, 0, st, got);
    chk("be_zero", got, mm[3]);

    do_txn(0, 1, BASE + 32'(4 * DEPTH), 32'hFFFF_FFFF, 4'hF, 0, 0, st, got);
    do_txn(1, 0, BASE + 32'(4 * DEPTH), 0, 4'hF, 0, 0, st, got);
    chk("out_of_range", got, 32'h0);

    preload(BASE + 32'h10, 32'h1);
    do_txn(1, 1, BASE + 32'h10, 32'h2, 4'hF, 0, 0, st, got);
    chk("rw_old", got, 32'h1);
    do_txn(1, 0, BASE + 32'h10, 0, 4'hF, 0, 0, st, got);
    chk("rw_new", got, 32'h2);

    do_txn(0, 1, BASE + 32'h18, 32'hDEAD_0000, 4'hF, 1, 32'h0000_BEEF, st, got);
    do_txn(1, 0, BASE + 32'h18, 0, 4'hF, 0, 0, st, got);
    chk("preload_wins", got, 32'h0000_BEEF);

    // Reset lands while a write is still stalled
    preload(BASE + 32'h14, 32'h77);
    @(posedge clk); #1;
`ifdef MEM_RANDOM_WAIT_EN
    m_lfsr = lfsr_next(m_lfsr);
`endif
    exp_s = TW; exp_rd_en = 0;
    write = 1; address = BASE + 32'h14; writedata = 32'h5; byteenable = 4'hF;
    txn = 1;
    @(posedge clk); #1;
    reset = 1;
    @(posedge clk); #1;
    write = 0; txn = 0;
    @(posedge clk); #1;
    reset = 0;
    m_lfsr = 16'hACE1;
    @(negedge clk);
    chk("readdata_reset_mid", readdata, 32'h0);
    do_txn(1, 0, BASE + 32'h14, 0, 4'hF, 0, 0, st, got);
    chk("reset_discard", got, 32'h77);

`ifdef MEM_RANDOM_WAIT_EN
    for (int i = 0; i < 8; i++) begin
      do_txn(1, 0, BASE + 32'(4 * i), 0, 4'hF, 0, 0, st, got);
      chk("random_stall_range", 32'(st >= 1 && st <= 4), 32'd1);
    end
`endif

    for (int i = 0; i < 150; i++) begin
      op = $urandom_range(0, 2);
      if ($urandom_range(0, 9) == 0) a = $urandom;
      else a = BASE + 32'($urandom_range(0, 4 * DEPTH + 15));
      d = $urandom;
      if ($urandom_range(0, 3) == 0)
        preload(BASE + 32'($urandom_range(0, 4 * DEPTH + 7)), $urandom);
      do_txn(op != 1, op != 0, a, d, 4'($urandom), (op != 0) &&
             ($urandom_range(0, 7) == 0), $urandom, st, got);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
